// File: rtl/float_to_int_conv.sv
// Multi-cycle float {sign, exp[5:0], frac[24:0]} to signed 32-bit integer converter.
// Optional macro F2I_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module float_to_int_conv #(
    parameter int BIAS = 31
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic [3:0]  status_out,
    output logic [2:0]  qual_lugar
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        SHIFT  = 3'd2,
        SIGN   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_op;
    logic               r_sign;
    logic [31:0]        r_mag;
    logic [5:0]         r_count;
    logic               r_leftShift;
    logic               r_guard;
    logic               r_sticky;
    logic [31:0]        r_data;
    logic [3:0]         r_status;

    logic signed [9:0]  w_d;
    logic signed [9:0]  w_k;
    logic [5:0]         w_absK;
    logic               w_isZero;
    logic               w_tooSmall;
    logic               w_tooBig;
    logic               w_minInt;
    logic               w_classified;
    logic               w_inexact;
    logic [31:0]        w_result;
    logic [3:0]         w_resStatus;

    assign w_d      = $signed({4'b0000, r_op[30:25]}) - BIAS_S;
    assign w_k      = w_d - 10'sd25;
    assign w_absK   = w_k[9] ? 6'(-w_k) : 6'(w_k);
    assign w_isZero = (r_op[30:0] == 31'd0);
`ifdef F2I_ROUND_NEAREST_EN
    assign w_tooSmall = (w_d < -1);
`else
    assign w_tooSmall = (w_d < 0);
`endif
    assign w_tooBig     = (w_d >= 31);
    assign w_minInt     = r_op[31] && (w_d == 31) && (r_op[24:0] == 25'd0);
    assign w_classified = w_isZero || w_tooSmall || w_tooBig;
    assign w_inexact    = r_guard || r_sticky;

    // Final sign/rounding stage: guard is the last bit shifted out, sticky the OR of all earlier ones.
`ifdef F2I_ROUND_NEAREST_EN
    logic        w_roundUp;
    logic [32:0] w_roundMag;
    logic        w_ovf;
    assign w_roundUp  = r_guard && (r_sticky || r_mag[0]);
    assign w_roundMag = {1'b0, r_mag} + {32'd0, w_roundUp};
    assign w_ovf      = r_sign ? (w_roundMag > 33'h080000000) : (w_roundMag > 33'h07FFFFFFF);

    always_comb begin
        w_result    = r_sign ? 32'(-w_roundMag) : w_roundMag[31:0];
        w_resStatus = w_inexact ? 4'd3 : 4'd0;
        if (w_ovf) begin
            w_result    = r_sign ? 32'h80000000 : 32'h7FFFFFFF;
            w_resStatus = 4'd1;
        end else if (w_roundMag == 33'd0) begin
            w_resStatus = 4'd2;
        end
    end
`else
    always_comb begin
        w_result    = r_sign ? -r_mag : r_mag;
        w_resStatus = w_inexact ? 4'd3 : 4'd0;
    end
`endif

    always_ff @(posedge clock_100kHz) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = UNPACK;
            UNPACK: begin
                if (w_classified)   w_next = DONE;
                else if (w_k == 0)  w_next = SIGN;
                else                w_next = SHIFT;
            end
            SHIFT:   if (r_count <= 6'd1) w_next = SIGN;
            SIGN:    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz) begin
        if (reset) begin
            r_op        <= '0;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_count     <= '0;
            r_leftShift <= 1'b0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_data      <= '0;
            r_status    <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) r_op <= op_in;
                UNPACK: begin
                    r_sign      <= r_op[31];
                    r_mag       <= {6'd0, 1'b1, r_op[24:0]};
                    r_count     <= w_absK;
                    r_leftShift <= (w_k > 0);
                    r_guard     <= 1'b0;
                    r_sticky    <= 1'b0;
                    // Special operands skip the shifter and publish their result directly.
                    if (w_isZero) begin
                        r_data   <= 32'd0;
                        r_status <= 4'd0;
                    end else if (w_tooSmall) begin
                        r_data   <= 32'd0;
                        r_status <= 4'd2;
                    end else if (w_tooBig) begin
                        if (w_minInt) begin
                            r_data   <= 32'h80000000;
                            r_status <= 4'd0;
                        end else begin
                            r_data   <= r_op[31] ? 32'h80000000 : 32'h7FFFFFFF;
                            r_status <= 4'd1;
                        end
                    end
                end
                SHIFT: begin
                    if (r_leftShift) begin
                        r_mag <= r_mag << 1;
                    end else begin
                        r_mag    <= r_mag >> 1;
                        r_guard  <= r_mag[0];
                        r_sticky <= r_sticky || r_guard;
                    end
                    r_count <= r_count - 6'd1;
                end
                SIGN: begin
                    r_data   <= w_result;
                    r_status <= w_resStatus;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign data_out   = r_data;
    assign status_out = r_status;
    assign qual_lugar = r_state;

endmodule

// File: tb/tb_float_to_int_conv.sv
// Self-checking bench for float_to_int_conv: directed cases, handshake stalls, reset abort and random operands.
`timescale 1ns/1ps
module tb_float_to_int_conv;

    logic        clock_100kHz;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic [2:0]  qual_lugar;

    int checks = 0;
    int errors = 0;

    localparam int BIAS = 31;

    float_to_int_conv #(.BIAS(BIAS)) dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_in        (op_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .status_out   (status_out),
        .qual_lugar   (qual_lugar)
    );

    initial clock_100kHz = 1'b0;
    always #5 clock_100kHz = ~clock_100kHz;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: value = sig * 2^(d-25), evaluated with plain integer arithmetic.
    function automatic void refConv(input logic [31:0] op, output logic [31:0] data,
                                    output logic [3:0] status, output int lat);
        int     d, k;
        longint sig, mag, rem, half, limit;
        logic   s;
        s   = op[31];
        d   = int'(op[30:25]) - BIAS;
        sig = longint'({1'b1, op[24:0]});
        lat = 2;
        if (op[30:0] == 31'd0) begin
            data = 0; status = 0; return;
        end
`ifdef F2I_ROUND_NEAREST_EN
        if (d < -1) begin
`else
        if (d < 0) begin
`endif
            data = 0; status = 2; return;
        end
        if (d >= 31) begin
            if (s && d == 31 && op[24:0] == 25'd0) begin
                data = 32'h80000000; status = 0;
            end else begin
                data = s ? 32'h80000000 : 32'h7FFFFFFF; status = 1;
            end
            return;
        end
        k = d - 25;
        if (k >= 0) begin
            mag = sig << k;
            rem = 0;
        end else begin
            mag = sig >> (-k);
            rem = sig - (mag << (-k));
        end
        lat = 3 + ((k < 0) ? -k : k);
        status = (rem != 0) ? 4'd3 : 4'd0;
`ifdef F2I_ROUND_NEAREST_EN
        if (k < 0) begin
            half = longint'(1) << (-k - 1);
            if (rem > half || (rem == half && mag[0])) mag = mag + 1;
        end
        limit = s ? 64'h80000000 : 64'h7FFFFFFF;
        if (mag > limit) begin
            data = s ? 32'h80000000 : 32'h7FFFFFFF; status = 1; return;
        end
        if (mag == 0) status = 2;
`else
        half  = 0;
        limit = 0;
`endif
        data = s ? 32'(-mag) : 32'(mag);
    endfunction

    // Drives one operand, measures latency, checks the result and optionally stalls out_ready.
    task automatic applyStimulus(input logic [31:0] op, input int holdCycles);
        logic [31:0] expData;
        logic [3:0]  expStatus;
        int          expLat, lat;
        logic        seen;
        refConv(op, expData, expStatus, expLat);
        @(negedge clock_100kHz);
        checkVal("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_in    = op;
        @(posedge clock_100kHz);
        #1 in_valid = 1'b0;
        op_in = $urandom;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock_100kHz);
            lat++;
            @(negedge clock_100kHz);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkVal("out_valid_timeout", 32'(seen), 32'd1);
        checkVal("latency", 32'(lat), 32'(expLat));
        checkVal("data_out", data_out, expData);
        checkVal("status_out", 32'(status_out), 32'(expStatus));
        checkVal("qual_done", 32'(qual_lugar), 32'd4);
        for (int i = 0; i < holdCycles; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                op_in    = 32'h7A000000;
            end
            @(negedge clock_100kHz);
            checkVal("hold_data", data_out, expData);
            checkVal("hold_status", 32'(status_out), 32'(expStatus));
            checkVal("hold_valid", 32'(out_valid), 32'd1);
            checkVal("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock_100kHz);
        out_ready = 1'b0;
        checkVal("back_idle", 32'(qual_lugar), 32'd0);
        checkVal("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_data"}, data_out, 32'd0);
        checkVal({tag, "_status"}, 32'(status_out), 32'd0);
        checkVal({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkVal({tag, "_state"}, 32'(qual_lugar), 32'd0);
        checkVal({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] op;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_in     = 32'd0;
        repeat (2) @(posedge clock_100kHz);
        @(negedge clock_100kHz);
        checkOutput("reset");
        reset = 1'b0;

        applyStimulus(32'h3E000000, 0);
        applyStimulus(32'h3F000000, 0);
        applyStimulus(32'hFC000000, 0);
        applyStimulus(32'h7C000000, 0);
        applyStimulus(32'h3C000000, 0);
        applyStimulus(32'h00000000, 0);
        applyStimulus(32'h80000000, 0);
        applyStimulus(32'h70000000, 0);
        applyStimulus(32'h7A000000, 0);
        applyStimulus(32'hBB000000, 0);
        applyStimulus(32'h3F800000, 10);
        applyStimulus(32'h3E000000, 0);

        // Abort a conversion while the shifter is busy.
        @(negedge clock_100kHz);
        in_valid = 1'b1;
        op_in    = 32'h3E000000;
        @(posedge clock_100kHz);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clock_100kHz);
        @(negedge clock_100kHz);
        checkVal("mid_shift_state", 32'(qual_lugar), 32'd2);
        reset = 1'b1;
        @(negedge clock_100kHz);
        checkOutput("abort");
        reset = 1'b0;
        applyStimulus(32'hBE000000, 0);

        for (int n = 0; n < 40; n++) begin
            op = {1'(($urandom)), 6'($urandom_range(24, 63)), 25'($urandom)};
            applyStimulus(op, (n % 8 == 0) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_to_int_conv.md
FLOAT_TO_INT_CONV -- requirements
Module: float_to_int_conv

Interface
REQ-001 SHALL have parameter BIAS, default 31, exponent bias of the 32-bit float format {sign[31], exp[30:25], frac[24:0]} with hidden leading 1.
REQ-002 SHALL have ports, in this order:
  clock_100kHz  in   1   single clock, all logic on rising edge
  reset         in   1   synchronous, active-high
  in_valid      in   1   op_in valid
  in_ready      out  1   block can accept op_in
  op_in         in   32  float operand
  out_valid     out  1   data_out/status_out valid
  out_ready     in   1   consumer accepts result
  data_out      out  32  two's-complement signed integer
  status_out    out  4   0 exact, 1 overflow, 2 underflow, 3 inexact
  qual_lugar    out  3   current FSM state code
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL implement FSM IDLE(0) -> UNPACK(1) -> SHIFT(2) -> SIGN(3) -> DONE(4) -> IDLE; qual_lugar SHALL equal the current state code.
REQ-005 in_ready SHALL be 1 only in IDLE; op_in SHALL be captured on the edge where in_valid && in_ready, moving to UNPACK.
REQ-006 UNPACK SHALL form sig = {1, frac} (26 bits), e = exp, d = e - BIAS, shift k = d - 25.
REQ-007 UNPACK classification, which SHALL go straight to DONE: op_in[30:0]==0 -> data_out 0, status 0; d < 0 -> data_out 0, status 2; d >= 31 -> overflow, except sign=1, d=31, frac=0 -> data_out 32'h80000000, status 0.
REQ-008 Overflow SHALL saturate: data_out 32'h7FFFFFFF if sign=0, 32'h80000000 if sign=1; status 1.
REQ-009 Otherwise UNPACK SHALL go to SHIFT with count |k|; SHIFT SHALL shift magnitude by one bit per cycle (left if k>0, right if k<0) and decrement count; when count==0 it SHALL go to SIGN (zero SHIFT cycles when k==0).
REQ-010 Right shifts SHALL accumulate a sticky bit of all discarded ones; the final value truncates toward zero.
REQ-011 SIGN SHALL negate the magnitude if sign=1 and set status 3 if sticky=1, else 0.
REQ-012 Latency from accept edge to out_valid SHALL be 3+|k| cycles (normal path) and 2 cycles (REQ-007 path).
REQ-013 In DONE, out_valid SHALL be 1 and data_out/status_out SHALL stay stable until out_ready=1; that edge SHALL return to IDLE, with out_valid low in IDLE.
REQ-014 A new operand SHALL NOT be accepted while any conversion is in flight; in_valid outside IDLE SHALL be ignored.

Reset
REQ-015 On reset the FSM SHALL go to IDLE; data_out=0, status_out=0, out_valid=0, qual_lugar=0, internal shift and count registers SHALL be 0, and in_ready SHALL be 1 on the next cycle.
REQ-016 Reset asserted in any state, including mid-SHIFT, SHALL abort the conversion with no result; the first operand accepted after reset SHALL convert correctly.

Configuration
REQ-017 Macro F2I_ROUND_NEAREST_EN: when defined, SIGN SHALL round the magnitude to nearest, ties to even, using guard and sticky bits; when undefined, it SHALL truncate toward zero.
REQ-018 With F2I_ROUND_NEAREST_EN, d == -1 SHALL take the normal path (k = -26). A zero result SHALL give status 2. A nonzero inexact result SHALL give status 3. A rounded magnitude exceeding the signed range SHALL saturate per REQ-008 with status 1.

Verification (BIAS=31)
REQ-019 op_in 32'h3E000000 (1.0) -> data_out 1, status 0, out_valid 28 cycles after accept.
REQ-020 op_in 32'h3F000000 (1.5) -> data_out 1, status 3; with F2I_ROUND_NEAREST_EN -> data_out 2, status 3.
REQ-021 op_in 32'hFC000000 -> data_out 32'h80000000, status 0; op_in 32'h7C000000 -> data_out 32'h7FFFFFFF, status 1; both after 2 cycles.
REQ-022 op_in 32'h3C000000 (0.5, no macro) -> data_out 0, status 2; op_in 32'h00000000 -> data_out 0, status 0.
REQ-023 out_ready held low 10 cycles after out_valid -> outputs stable, in_ready 0, second in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-024 reset pulsed during SHIFT of 32'h3E000000 -> all outputs 0 next cycle; then op_in 32'hBE000000 -> data_out 32'hFFFFFFFF, status 0.
